counter_sched: RTL and testbench
================================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: WIDTH, 4, width of the shared count datapath and of each length input.
REQ-002 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Port: req  in  2  per-requester request level; held high until done or deliberately withdrawn.
REQ-005 Port: len0  in  WIDTH  terminal count for requester 0; sampled only at grant.
REQ-006 Port: len1  in  WIDTH  terminal count for requester 1; sampled only at grant.
REQ-007 Port: pause  in  1  when high, freezes the count during RUN.
REQ-008 Port: gnt  out  2  one-hot grant, high for the owner throughout RUN.
REQ-009 Port: busy  out  1  high in RUN and DONE.
REQ-010 Port: cnt  out  WIDTH  current count of the shared counter.
REQ-011 Port: done  out  2  one-cycle completion pulse to the owner.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE; all outputs registered.
REQ-013 IDLE: with any req high, SHALL select owner, latch len_q from the owner's len, clear cnt to 0, and enter RUN; gnt[owner] rises on that same edge, one cycle after req is seen.
REQ-014 Arbitration SHALL be round-robin via a priority pointer: when both req are high in IDLE, the requester not served last wins.
REQ-015 RUN: if cnt == len_q, SHALL enter DONE with cnt holding; else if pause = 0, cnt increments by 1; else cnt holds.
REQ-016 The RUN cycle count SHALL be len_q + 1 plus the number of paused cycles; len_q = 0 gives one RUN cycle.
REQ-017 cnt SHALL never exceed len_q and never wrap; len = 2^WIDTH-1 reaches 15 (WIDTH = 4) without overflow.
REQ-018 DONE: SHALL pulse done[owner] for exactly one cycle, drop gnt, toggle the pointer away from owner, and return to IDLE next cycle.
REQ-019 A requester still high after its done pulse SHALL be re-eligible only from IDLE, behind the other requester if that one is also pending.
REQ-020 req[owner] falling during RUN SHALL abort: next state IDLE, gnt dropped, no done pulse, cnt holds, pointer toggles.
REQ-021 Changes to len0/len1 after grant SHALL have no effect on the current run.
REQ-022 A request from the non-owner during RUN SHALL be held pending, not dropped or preempted.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, cnt 0, gnt 0, done 0, busy 0, len_q 0, and pointer to favour requester 0.
REQ-024 Reset asserted mid-RUN SHALL abandon the run with no done pulse; after release, the first grant follows REQ-013/014.
REQ-025 Reset release SHALL produce no spurious gnt or done pulse.

Structure
REQ-026 Package counter_sched_pkg SHALL hold the FSM state enum and the default WIDTH constant.
REQ-027 Counter datapath SHALL be sub-module cnt_core (WIDTH-bit, clear, enable, async active-low reset); FSM and arbiter live in counter_sched.

Verification
REQ-028 Reset release, req = 01, len0 = 3, pause = 0 -> gnt = 01 next cycle, cnt 0,1,2,3, done = 01 pulse one cycle after cnt = 3, busy low afterwards.
REQ-029 Both req held from reset, len0 = 2, len1 = 1 -> requester 0 served first, then requester 1, then requester 0 again; strict alternation.
REQ-030 req = 10, len1 = 5, pause high for 3 cycles at cnt = 2 -> cnt holds at 2 for 3 cycles, total RUN 9 cycles, done = 10.
REQ-031 len0 = 0 -> exactly one RUN cycle with cnt = 0, then done pulse; len0 = 15 -> cnt reaches 15, no wrap.
REQ-032 req[0] dropped at cnt = 4 of len0 = 10 -> gnt falls, no done pulse, cnt holds 4; pending req[1] granted from IDLE.
REQ-033 reset_n low at cnt = 6 mid-RUN -> all outputs 0 immediately, no done pulse; after release, req = 11 grants requester 0.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared definitions for the counter scheduler.
//   - WIDTH_DEF : default width of the count datapath and length inputs
//   - state_t   : scheduler FSM states (IDLE, RUN, DONE)
//   - onehot2   : converts a one-bit requester index to a 2-bit one-hot vector
package counter_sched_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic sel);
        logic [1:0] vec;
        if (sel) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/counter_sched_cnt_core.sv
// cnt_core: WIDTH-bit up-counter for the scheduler datapath.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, clears the count
//   clr     : synchronous clear to zero (has priority over en)
//   en      : increment by one when high
//   cnt     : registered count value
module cnt_core #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear wins over increment; otherwise hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/counter_sched.sv
// counter_sched: two-requester round-robin scheduler for one shared counter.
// The granted requester owns the counter, which runs from 0 up to that
// requester's length (latched at grant), then a one-cycle done pulse is sent.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   req     : per-requester request levels
//   len0/1  : terminal counts, sampled at grant only
//   pause   : freezes the count while running
//   gnt     : one-hot grant, high for the owner throughout RUN
//   busy    : high in RUN and DONE
//   cnt     : shared counter value
//   done    : one-cycle completion pulse to the owner
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             pause,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic [WIDTH-1:0] cnt,
    output logic [1:0]       done
);

    state_t           state_r, state_s;
    logic             owner_r, owner_s;
    logic             ptr_r, ptr_s;      // requester favoured when both request
    logic [WIDTH-1:0] len_r, len_s;
    logic [1:0]       gnt_r, done_r;
    logic             busy_r;
    logic             cnt_clr_s, cnt_en_s;
    logic [WIDTH-1:0] cnt_s;

    cnt_core #(.WIDTH(WIDTH)) u_cnt_core (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .cnt     (cnt_s)
    );

    // Next-state, arbitration and counter control.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        len_s     = len_r;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) begin
                        owner_s = ptr_r;
                    end else begin
                        owner_s = req[1];
                    end
                    if (owner_s) begin
                        len_s = len1;
                    end else begin
                        len_s = len0;
                    end
                    cnt_clr_s = 1'b1;
                    state_s   = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Withdrawal by the owner aborts the run; the count is left
                // where it stopped and the other requester gets priority.
                if (!req[owner_r]) begin
                    state_s = ST_IDLE;
                    ptr_s   = ~owner_r;
                end else if (cnt_s == len_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s  = ST_RUN;
                    cnt_en_s = ~pause;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                ptr_s   = ~owner_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, owner, pointer, latched length and registered outputs.
    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            ptr_r   <= 1'b0;
            len_r   <= {WIDTH{1'b0}};
            gnt_r   <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            len_r   <= len_s;
            gnt_r   <= (state_s == ST_RUN)  ? onehot2(owner_s) : 2'b00;
            done_r  <= (state_s == ST_DONE) ? onehot2(owner_s) : 2'b00;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign gnt  = gnt_r;
    assign done = done_r;
    assign busy = busy_r;
    assign cnt  = cnt_s;

endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed self-checking bench for counter_sched.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_sched;

    logic       clock;
    logic       reset_n;
    logic [1:0] req;
    logic [3:0] len0, len1;
    logic       pause;
    logic [1:0] gnt;
    logic       busy;
    logic [3:0] cnt;
    logic [1:0] done;

    int checks_total;
    int checks_failed;

    counter_sched #(.WIDTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .len0    (len0),
        .len1    (len1),
        .pause   (pause),
        .gnt     (gnt),
        .busy    (busy),
        .cnt     (cnt),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) else begin
            checks_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] g, input logic [1:0] d,
                           input logic b, input logic [3:0] c);
        chk({tag, ".gnt"},  {30'd0, gnt},  {30'd0, g});
        chk({tag, ".done"}, {30'd0, done}, {30'd0, d});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, ".cnt"},  {28'd0, cnt},  {28'd0, c});
    endtask

    initial begin
        int exp_c [9];
        checks_total  = 0;
        checks_failed = 0;
        reset_n = 1'b0;
        req     = 2'b00;
        len0    = 4'd0;
        len1    = 4'd0;
        pause   = 1'b0;
        tick();
        tick();
        chk_all("reset", 2'b00, 2'b00, 1'b0, 4'd0);

        // Release with no request: no spurious activity.
        reset_n = 1'b1;
        tick();
        chk_all("release", 2'b00, 2'b00, 1'b0, 4'd0);

        // Basic run on requester 0, len0 = 3; len0 changed after grant.
        req  = 2'b01;
        len0 = 4'd3;
        tick();
        chk_all("r0.c0", 2'b01, 2'b00, 1'b1, 4'd0);
        len0 = 4'd9;
        tick(); chk("r0.c1", {28'd0, cnt}, 32'd1);
        tick(); chk("r0.c2", {28'd0, cnt}, 32'd2);
        tick(); chk_all("r0.c3", 2'b01, 2'b00, 1'b1, 4'd3);
        tick(); chk_all("r0.done", 2'b00, 2'b01, 1'b1, 4'd3);
        req = 2'b00;
        tick(); chk_all("r0.idle", 2'b00, 2'b00, 1'b0, 4'd3);

        // Both requesting from reset: strict alternation 0,1,0.
        reset_n = 1'b0;
        req  = 2'b11;
        len0 = 4'd2;
        len1 = 4'd1;
        tick();
        reset_n = 1'b1;
        tick(); chk("alt.g0", {30'd0, gnt}, 32'd1);
        tick(); tick();
        chk("alt.c2", {28'd0, cnt}, 32'd2);
        tick(); chk("alt.d0", {30'd0, done}, 32'd1);
        tick(); chk_all("alt.idle0", 2'b00, 2'b00, 1'b0, 4'd2);
        tick(); chk_all("alt.g1", 2'b10, 2'b00, 1'b1, 4'd0);
        tick(); chk("alt.c1", {28'd0, cnt}, 32'd1);
        tick(); chk("alt.d1", {30'd0, done}, 32'd2);
        tick(); tick();
        chk("alt.g0b", {30'd0, gnt}, 32'd1);

        // Requester 1, len1 = 5, pause for 3 cycles at cnt = 2.
        reset_n = 1'b0;
        req  = 2'b10;
        len1 = 4'd5;
        tick();
        reset_n = 1'b1;
        exp_c = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("pause.run%0d.cnt", i), {28'd0, cnt}, {28'd0, exp_c[i][3:0]});
            chk($sformatf("pause.run%0d.gnt", i), {30'd0, gnt}, 32'd2);
            if (i == 2) pause = 1'b1;
            if (i == 5) pause = 1'b0;
        end
        tick(); chk_all("pause.done", 2'b00, 2'b10, 1'b1, 4'd5);
        req = 2'b00;
        tick(); chk_all("pause.idle", 2'b00, 2'b00, 1'b0, 4'd5);

        // len0 = 0: single RUN cycle; then len0 = 15: full range, no wrap.
        reset_n = 1'b0;
        req  = 2'b01;
        len0 = 4'd0;
        tick();
        reset_n = 1'b1;
        tick(); chk_all("len0.run", 2'b01, 2'b00, 1'b1, 4'd0);
        tick(); chk_all("len0.done", 2'b00, 2'b01, 1'b1, 4'd0);
        req = 2'b00;
        tick();
        req  = 2'b01;
        len0 = 4'd15;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("len15.c%0d", i), {28'd0, cnt}, i);
        end
        tick(); chk_all("len15.done", 2'b00, 2'b01, 1'b1, 4'd15);
        req = 2'b00;
        tick(); chk_all("len15.idle", 2'b00, 2'b00, 1'b0, 4'd15);

        // Abort by req[0] at cnt = 4; req[1] pending meanwhile.
        reset_n = 1'b0;
        req  = 2'b01;
        len0 = 4'd10;
        len1 = 4'd2;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        req = 2'b11;
        tick(); tick(); tick();
        chk_all("abort.c4", 2'b01, 2'b00, 1'b1, 4'd4);
        req = 2'b10;
        tick(); chk_all("abort.idle", 2'b00, 2'b00, 1'b0, 4'd4);
        tick(); chk_all("abort.g1", 2'b10, 2'b00, 1'b1, 4'd0);
        req = 2'b00;

        // Reset at cnt = 6 mid-run; then req = 11 grants requester 0.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req  = 2'b01;
        len0 = 4'd10;
        for (int i = 0; i < 7; i++) tick();
        chk_all("midrst.c6", 2'b01, 2'b00, 1'b1, 4'd6);
        reset_n = 1'b0;
        #1;
        chk_all("midrst.async", 2'b00, 2'b00, 1'b0, 4'd0);
        req = 2'b11;
        tick(); chk_all("midrst.held", 2'b00, 2'b00, 1'b0, 4'd0);
        reset_n = 1'b1;
        tick(); chk_all("midrst.g0", 2'b01, 2'b00, 1'b1, 4'd0);

        $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
        $finish;
    end

endmodule
